// File: rtl/disp_pkg.sv
// Shared types and helpers for the display-sharing arbiter.
//   BLANK_SEG   : all segments off (patterns are active-low)
//   arb_state_t : arbiter FSM states
//   seg_frame_t : one 4-digit frame {d3,d2,d1,d0}
//   seg_frame() : slices frame idx out of a packed bus of up to MAX_REQ frames
package disp_pkg;

    localparam logic [7:0]  BLANK_SEG = 8'hFF;
    localparam int unsigned MAX_REQ   = 8;

    typedef logic [31:0] seg_frame_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    function automatic seg_frame_t seg_frame(input logic [MAX_REQ*32-1:0] frames,
                                             input int unsigned          idx);
        return frames[32*idx +: 32];
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req   : request vector
//   last  : index of the previous owner; search starts at (last+1) mod NREQ
//   valid : at least one request is set
//   idx   : first requesting index found from the start point, wrapping
module rr_picker #(
    parameter int unsigned NREQ = 3
) (
    input  logic [NREQ-1:0]         req,
    input  logic [$clog2(NREQ)-1:0] last,
    output logic                    valid,
    output logic [$clog2(NREQ)-1:0] idx
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    int unsigned       start;
    int unsigned       pos;
    int unsigned       sum;
    logic              hit;

    always_comb begin
        start = (int'(last) >= int'(NREQ) - 1) ? 0 : int'(last) + 1;
        // Rotate so the start point lands at bit 0.
        dbl   = {req, req};
        rot   = NREQ'(dbl >> start);
        hit   = 1'b0;
        pos   = 0;
        // Descending scan so the lowest set bit wins.
        for (int unsigned p = NREQ; p > 0; p--) begin
            if (rot[p-1]) begin
                hit = 1'b1;
                pos = p - 1;
            end
        end
        // Un-rotate back to an absolute index.
        sum = start + pos;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        valid = hit;
        idx   = $clog2(NREQ)'(sum);
    end

endmodule

// File: rtl/disp_share_arbiter.sv
// Time-shares the 4-digit seven-segment multiplexer between NREQ pattern
// sources: round-robin ownership with a fixed dwell, and a blank gap between
// owners so no mixed frame is ever displayed.
//   clk, reset      : clock, synchronous active-high reset
//   req[NREQ]       : level requests from the pattern sources
//   frame[NREQ*32]  : source i's digits at frame[32*i +: 32], {d3,d2,d1,d0}
//   gnt[NREQ]       : one-hot current owner, zero when none
//   in3..in0        : registered digit patterns towards disp_mux
//   busy            : high while a source owns the display
module disp_share_arbiter
    import disp_pkg::*;
#(
    parameter int unsigned NREQ  = 3,
    parameter int unsigned DWELL = 200_000_000,
    parameter int unsigned GAP   = 10_000_000,
    parameter int unsigned CW    = 28
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*32-1:0]   frame,
    output logic [NREQ-1:0]      gnt,
    output logic [7:0]           in3,
    output logic [7:0]           in2,
    output logic [7:0]           in1,
    output logic [7:0]           in0,
    output logic                 busy
);

    localparam int unsigned     IW         = $clog2(NREQ);
    localparam int unsigned     FW         = MAX_REQ * 32;
    localparam logic [CW-1:0]   DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0]   GAP_LAST   = CW'(GAP - 1);
    localparam logic [IW-1:0]   LAST_RST   = IW'(NREQ - 1);

    // The GAP parameter shadows the enum literal, so states are package-qualified.
    arb_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    seg_frame_t       seg_q, seg_d;
    logic             busy_q, busy_d;

    logic             pick_valid;
    logic [IW-1:0]    pick_idx;
    logic [NREQ-1:0]  owner_mask;
    logic             owner_req;
    logic             others_req;
    logic [FW-1:0]    frame_ext;

    assign frame_ext  = FW'(frame);
    assign owner_mask = NREQ'(1) << last_q;
    assign owner_req  = |(req & owner_mask);
    assign others_req = |(req & ~owner_mask);

    rr_picker #(
        .NREQ (NREQ)
    ) u_picker (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= disp_pkg::IDLE;
            cnt_q   <= '0;
            last_q  <= LAST_RST;
            gnt_q   <= '0;
            seg_q   <= {4{BLANK_SEG}};
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            seg_q   <= seg_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = disp_pkg::IDLE;
        cnt_d   = '0;
        last_d  = last_q;
        unique case (state_q)
            disp_pkg::IDLE: begin
                if (pick_valid) begin
                    state_d = disp_pkg::SHOW;
                    last_d  = pick_idx;
                end
            end
            disp_pkg::SHOW: begin
                state_d = disp_pkg::SHOW;
                cnt_d   = cnt_q + CW'(1);
                if (!owner_req || (cnt_q == DWELL_LAST && others_req)) begin
                    state_d = disp_pkg::GAP;
                    cnt_d   = '0;
                end else if (cnt_q == DWELL_LAST) begin
                    // Sole requester keeps the display: restart the dwell, no blank.
                    cnt_d = '0;
                end
            end
            disp_pkg::GAP: begin
                state_d = disp_pkg::GAP;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (pick_valid) begin
                        state_d = disp_pkg::SHOW;
                        last_d  = pick_idx;
                    end else begin
                        state_d = disp_pkg::IDLE;
                    end
                end
            end
            default: begin
                state_d = disp_pkg::IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d  = '0;
        busy_d = 1'b0;
        seg_d  = {4{BLANK_SEG}};
        if (state_d == disp_pkg::SHOW) begin
            gnt_d  = NREQ'(1) << last_d;
            busy_d = 1'b1;
        end
        // Frame follows the grant by one cycle; the entry cycle stays blank.
        if (state_q == disp_pkg::SHOW && state_d == disp_pkg::SHOW) begin
            seg_d = seg_frame(frame_ext, int'(last_q));
        end
    end

    assign gnt              = gnt_q;
    assign {in3, in2, in1, in0} = seg_q;
    assign busy             = busy_q;

endmodule
